// File: rtl/placement_search_if.sv
// Evaluator-side channel: placement_search drives it as master, sub_evaluator answers as slave.
// Carries the field-copy write port, the candidate shape/offset, the evaluate pulse and the result.
interface placement_search_if #(
    parameter int COLS    = 10,
    parameter int SCORE_W = 32
);
    logic [4:0]         ev_write_address;
    logic [COLS-1:0]    ev_write_data;
    logic               ev_write_enable;
    logic [3:0]         ev_shapex;
    logic [15:0]        ev_shape;
    logic               ev_evaluate;
    logic [SCORE_W-1:0] ev_score;
    logic               ev_busy;

    modport master (
        output ev_write_address, ev_write_data, ev_write_enable,
        output ev_shapex, ev_shape, ev_evaluate,
        input  ev_score, ev_busy
    );

    modport slave (
        input  ev_write_address, ev_write_data, ev_write_enable,
        input  ev_shapex, ev_shape, ev_evaluate,
        output ev_score, ev_busy
    );
endinterface

// File: rtl/placement_search.sv
// Sweeps NUM_ROT x COLS placements through one sub_evaluator, recopying the field each time, and keeps the lowest score.
// Optional macro PLACEMENT_SEARCH_DEDUP_ROT_EN skips rotations whose bitmap repeats an earlier rotation.
module placement_search #(
    parameter int ROWS    = 25,
    parameter int COLS    = 10,
    parameter int NUM_ROT = 4,
    parameter int SCORE_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [16*NUM_ROT-1:0] shapes,
    output logic [4:0]            fld_rd_addr,
    input  logic [COLS-1:0]       fld_rd_data,
    placement_search_if.master    ev,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [1:0]            best_rot,
    output logic [3:0]            best_x,
    output logic [SCORE_W-1:0]    best_score
);
    localparam int CW = $clog2(ROWS + 2);
    localparam logic [SCORE_W-1:0] SCORE_NONE = '1;

    typedef enum logic [3:0] {
        IDLE, WAIT_IDLE, COPY, FIRE, WAIT_RISE, WAIT_FALL, NEXT, FINISH
`ifdef PLACEMENT_SEARCH_DEDUP_ROT_EN
        , DEDUP
`endif
    } state_t;

    state_t              state;
    logic [1:0]          rot;
    logic [3:0]          x;
    logic [CW-1:0]       cyc;
    logic                rd_vld_p1;
    logic [4:0]          rd_addr_p1;
    logic [SCORE_W-1:0]  score_p0;
    logic                x_last;
    logic                rot_last;
    logic [3:0]          nx;
    logic [1:0]          nrot;

    function automatic logic [15:0] shape_of(input logic [16*NUM_ROT-1:0] s, input logic [1:0] r);
        return s[16*r +: 16];
    endfunction

`ifdef PLACEMENT_SEARCH_DEDUP_ROT_EN
    function automatic logic is_dup(input logic [16*NUM_ROT-1:0] s, input logic [1:0] r);
        logic hit;
        hit = 1'b0;
        for (int q = 0; q < NUM_ROT; q++) begin
            if (q < int'(r) && s[16*q +: 16] == s[16*r +: 16]) hit = 1'b1;
        end
        return hit;
    endfunction
`endif

    always_comb begin
        x_last   = (x == 4'(COLS - 1));
        rot_last = (rot == 2'(NUM_ROT - 1));
        nx       = x_last ? 4'd0 : x + 4'd1;
        nrot     = x_last ? rot + 2'd1 : rot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            busy                <= 1'b0;
            done                <= 1'b0;
            valid               <= 1'b0;
            best_rot            <= '0;
            best_x              <= '0;
            best_score          <= SCORE_NONE;
            fld_rd_addr         <= '0;
            ev.ev_evaluate      <= 1'b0;
            ev.ev_write_enable  <= 1'b0;
            ev.ev_write_address <= '0;
            ev.ev_write_data    <= '0;
            ev.ev_shapex        <= '0;
            rot                 <= '0;
            x                   <= '0;
            cyc                 <= '0;
            rd_vld_p1           <= 1'b0;
        end else begin
            done           <= 1'b0;
            ev.ev_evaluate <= 1'b0;

            // Stage p1: read address issued last cycle, RAM data arriving now
            rd_vld_p1  <= (state == COPY) && (cyc < CW'(ROWS));
            rd_addr_p1 <= fld_rd_addr;

            // Stage p2: registered write into the evaluator's field copy
            ev.ev_write_enable  <= rd_vld_p1;
            ev.ev_write_address <= rd_addr_p1;
            ev.ev_write_data    <= fld_rd_data;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        valid      <= 1'b0;
                        best_score <= SCORE_NONE;
                        best_rot   <= '0;
                        best_x     <= '0;
                        rot        <= '0;
                        x          <= '0;
                        state      <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (!ev.ev_busy) begin
                        state        <= COPY;
                        cyc          <= '0;
                        fld_rd_addr  <= '0;
                        ev.ev_shapex <= x;
                        ev.ev_shape  <= shape_of(shapes, rot);
                    end
                end
                COPY: begin
                    cyc <= cyc + 1'b1;
                    if (fld_rd_addr != 5'(ROWS - 1)) fld_rd_addr <= fld_rd_addr + 5'd1;
                    if (cyc == CW'(ROWS + 1)) begin
                        state          <= FIRE;
                        ev.ev_evaluate <= 1'b1;
                    end
                end
                FIRE: state <= WAIT_RISE;
                WAIT_RISE: begin
                    if (ev.ev_busy) state <= WAIT_FALL;
                end
                WAIT_FALL: begin
                    if (!ev.ev_busy) begin
                        score_p0 <= ev.ev_score;
                        state    <= NEXT;
                    end
                end
                NEXT: begin
                    // Strict compare so ties keep the earlier candidate
                    if (score_p0 != SCORE_NONE && score_p0 < best_score) begin
                        best_score <= score_p0;
                        best_rot   <= rot;
                        best_x     <= x;
                        valid      <= 1'b1;
                    end
                    if (x_last && rot_last) begin
                        state <= FINISH;
                    end else begin
                        x   <= nx;
                        rot <= nrot;
`ifdef PLACEMENT_SEARCH_DEDUP_ROT_EN
                        if (x_last) begin
                            state <= DEDUP;
                        end else begin
                            state        <= COPY;
                            cyc          <= '0;
                            fld_rd_addr  <= '0;
                            ev.ev_shapex <= nx;
                            ev.ev_shape  <= shape_of(shapes, nrot);
                        end
`else
                        state        <= COPY;
                        cyc          <= '0;
                        fld_rd_addr  <= '0;
                        ev.ev_shapex <= nx;
                        ev.ev_shape  <= shape_of(shapes, nrot);
`endif
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`ifdef PLACEMENT_SEARCH_DEDUP_ROT_EN
                DEDUP: begin
                    if (is_dup(shapes, rot)) begin
                        if (rot_last) state <= FINISH;
                        else          rot   <= rot + 2'd1;
                    end else begin
                        state        <= COPY;
                        cyc          <= '0;
                        fld_rd_addr  <= '0;
                        ev.ev_shapex <= x;
                        ev.ev_shape  <= shape_of(shapes, rot);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_placement_search.sv
// Bench for placement_search: field RAM and evaluator are behavioural models; results are checked
// against a reference that picks the minimum non-failing score and its earliest candidate.
`timescale 1ns/1ps
module tb_placement_search;
    localparam int ROWS    = 25;
    localparam int COLS    = 10;
    localparam int NUM_ROT = 4;
    localparam int SW      = 32;
    localparam logic [SW-1:0] NONE = '1;
`ifdef PLACEMENT_SEARCH_DEDUP_ROT_EN
    localparam int EXP_O_EVALS = 10;
`else
    localparam int EXP_O_EVALS = 40;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [16*NUM_ROT-1:0] shapes = '0;
    logic [4:0]            fld_rd_addr;
    logic [COLS-1:0]       fld_rd_data = '0;
    logic                  busy, done, valid;
    logic [1:0]            best_rot;
    logic [3:0]            best_x;
    logic [SW-1:0]         best_score;

    placement_search_if #(.COLS(COLS), .SCORE_W(SW)) evif ();

    placement_search #(.ROWS(ROWS), .COLS(COLS), .NUM_ROT(NUM_ROT), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .shapes(shapes),
        .fld_rd_addr(fld_rd_addr), .fld_rd_data(fld_rd_data), .ev(evif),
        .busy(busy), .done(done), .valid(valid),
        .best_rot(best_rot), .best_x(best_x), .best_score(best_score)
    );

    always #5 clk = ~clk;

    logic [COLS-1:0] mem [ROWS];
    logic [SW-1:0]   score_tab [NUM_ROT][COLS];
    int              cand_r[$];
    int              cand_x[$];
    int              long_lat = 0;
    int              errors = 0;
    int              checks = 0;
    int              last_evals = 0;

    // Master field RAM: one-cycle read latency
    always @(posedge clk)
        fld_rd_data <= (int'(fld_rd_addr) < ROWS) ? mem[int'(fld_rd_addr)] : '0;

    // Evaluator model plus protocol monitors
    logic          m_busy = 1'b0;
    logic [SW-1:0] m_score = '0;
    logic [SW-1:0] m_pend = '0;
    logic [3:0]    m_x = '0;
    logic          busy_q = 1'b0;
    logic          eval_q = 1'b0;
    int            m_lat = 0, ev_k = 0, wr_cnt = 0;
    int            eval_total = 0, done_total = 0, copy_err = 0, proto_err = 0;

    assign evif.ev_busy  = m_busy;
    assign evif.ev_score = m_score;

    always @(posedge clk) begin
        busy_q <= busy;
        eval_q <= evif.ev_evaluate;
        if (done) done_total <= done_total + 1;
        if (evif.ev_write_enable && (m_busy || evif.ev_evaluate)) proto_err <= proto_err + 1;
        if (evif.ev_evaluate && (eval_q || m_busy)) proto_err <= proto_err + 1;

        if (busy && !busy_q) begin
            ev_k   <= 0;
            wr_cnt <= 0;
        end else if (evif.ev_write_enable) begin
            if (evif.ev_write_address != 5'(wr_cnt) || evif.ev_write_data != mem[wr_cnt % ROWS])
                copy_err <= copy_err + 1;
            wr_cnt <= wr_cnt + 1;
        end else if (evif.ev_evaluate) begin
            if (wr_cnt != ROWS) copy_err <= copy_err + 1;
            wr_cnt     <= 0;
            ev_k       <= ev_k + 1;
            eval_total <= eval_total + 1;
            if (ev_k < cand_r.size()) begin
                if (evif.ev_shapex != 4'(cand_x[ev_k]) || evif.ev_shape != shapes[16*cand_r[ev_k] +: 16])
                    proto_err <= proto_err + 1;
                m_pend <= score_tab[cand_r[ev_k]][cand_x[ev_k]];
            end else begin
                proto_err <= proto_err + 1;
                m_pend    <= NONE;
            end
            m_x    <= evif.ev_shapex;
            m_busy <= 1'b1;
            m_lat  <= (long_lat > 0) ? long_lat : int'($urandom_range(0, 3));
        end

        if (m_busy && !evif.ev_evaluate) begin
            if (m_lat == 0) begin
                m_busy  <= 1'b0;
                m_score <= m_pend;
                if (evif.ev_shapex != m_x) proto_err <= proto_err + 1;
            end else begin
                m_lat <= m_lat - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_search(input logic [16*NUM_ROT-1:0] shp);
        bit dup;
        shapes = shp;
        cand_r.delete();
        cand_x.delete();
        for (int r = 0; r < NUM_ROT; r++) begin
            dup = 1'b0;
`ifdef PLACEMENT_SEARCH_DEDUP_ROT_EN
            for (int q = 0; q < r; q++) if (shp[16*q +: 16] == shp[16*r +: 16]) dup = 1'b1;
`endif
            if (!dup) for (int c = 0; c < COLS; c++) begin
                cand_r.push_back(r);
                cand_x.push_back(c);
            end
        end
    endtask

    function automatic logic [16*NUM_ROT-1:0] rand_shapes(input bit allow_dup);
        logic [16*NUM_ROT-1:0] s;
        s = '0;
        for (int r = 0; r < NUM_ROT; r++) begin
            if (allow_dup && r > 0 && $urandom_range(0, 1) == 1) s[16*r +: 16] = s[16*(r-1) +: 16];
            else s[16*r +: 16] = 16'(r * 4096 + int'($urandom_range(1, 4095)));
        end
        return s;
    endfunction

    task automatic rand_scores(input int maxv, input int fail_pct);
        for (int r = 0; r < NUM_ROT; r++)
            for (int c = 0; c < COLS; c++)
                score_tab[r][c] = ($urandom_range(0, 99) < fail_pct) ? NONE : SW'($urandom_range(0, maxv));
    endtask

    task automatic check_results(input string tag);
        logic [SW-1:0] lo, s;
        bit any;
        int bi;
        any = 1'b0; lo = NONE; bi = -1;
        foreach (cand_r[i]) begin
            s = score_tab[cand_r[i]][cand_x[i]];
            if (s != NONE && (!any || s < lo)) begin lo = s; any = 1'b1; end
        end
        foreach (cand_r[i]) if (any && bi < 0 && score_tab[cand_r[i]][cand_x[i]] == lo) bi = i;
        check({tag, ".valid"}, valid, any);
        check({tag, ".score"}, best_score, any ? lo : NONE);
        if (any) begin
            check({tag, ".rot"}, best_rot, cand_r[bi]);
            check({tag, ".x"}, best_x, cand_x[bi]);
        end else begin
            check({tag, ".rot"}, best_rot, 0);
            check({tag, ".x"}, best_x, 0);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".done"}, done, 1);
    endtask

    task automatic run_search(input string tag);
        int e0, d0;
        e0 = eval_total;
        d0 = done_total;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, ".busy_on"}, busy, 1);
        wait_done(tag);
        check({tag, ".busy_off"}, busy, 0);
        check_results(tag);
        @(negedge clk);
        last_evals = eval_total - e0;
        check({tag, ".evals"}, last_evals, cand_r.size());
        check({tag, ".dones"}, done_total - d0, 1);
        check({tag, ".copy"}, copy_err, 0);
        check({tag, ".proto"}, proto_err, 0);
    endtask

    initial begin
        int n, e0, d0;
        for (int k = 0; k < ROWS; k++) mem[k] = '0;
        for (int r = 0; r < NUM_ROT; r++) for (int c = 0; c < COLS; c++) score_tab[r][c] = NONE;

        repeat (2) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.valid", valid, 0);
        check("rst.eval", evif.ev_evaluate, 0);
        check("rst.we", evif.ev_write_enable, 0);
        check("rst.rot", best_rot, 0);
        check("rst.x", best_x, 0);
        check("rst.score", best_score, NONE);
        check("rst.addr", fld_rd_addr, 0);
        check("rst.waddr", evif.ev_write_address, 0);
        check("rst.wdata", evif.ev_write_data, 0);
        check("rst.shapex", evif.ev_shapex, 0);
        rst = 1'b0;

        // O piece in every rotation, empty field, score rises with rotation and column
        set_search({4{16'h0033}});
        for (int r = 0; r < NUM_ROT; r++) for (int c = 0; c < COLS; c++) score_tab[r][c] = SW'(100 + 10*r + c);
        run_search("opiece");
        check("opiece.best", {best_rot, best_x, best_score}, {2'd0, 4'd0, 32'd100});
        check("opiece.count", last_evals, EXP_O_EVALS);

        set_search(rand_shapes(1'b0));
        rand_scores(10, 100);
        run_search("allfail");

        set_search({16'h4444, 16'h0F00, 16'h2222, 16'h000F});
        for (int r = 0; r < NUM_ROT; r++) for (int c = 0; c < COLS; c++) score_tab[r][c] = 900;
        score_tab[1][3] = 500;
        score_tab[2][1] = 500;
        run_search("tie");
        check("tie.best", {best_rot, best_x, best_score}, {2'd1, 4'd3, 32'd500});

        for (int k = 0; k < ROWS; k++) mem[k] = COLS'(k);
        set_search(rand_shapes(1'b0));
        rand_scores(1000, 10);
        run_search("rows");

        // Reset while the evaluator is mid-run; the next search must wait it out
        long_lat = 22;
        set_search(rand_shapes(1'b0));
        rand_scores(50, 15);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (evif.ev_evaluate !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("midrst.fire", evif.ev_evaluate, 1);
        repeat (3) @(negedge clk);
        check("midrst.evbusy", evif.ev_busy, 1);
        rst = 1'b1;
        long_lat = 0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", busy, 0);
        check("midrst.valid", valid, 0);
        run_search("midrst.after");

        // start held through a whole search with extra toggles in the middle
        set_search(rand_shapes(1'b1));
        rand_scores(40, 20);
        e0 = eval_total;
        d0 = done_total;
        @(negedge clk); start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
            if (n == 200 || n == 700) start = 1'b0;
            else if (n == 203 || n == 704) start = 1'b1;
        end
        start = 1'b0;
        check("hold.done", done, 1);
        check_results("hold");
        repeat (10) @(negedge clk);
        check("hold.idle", busy, 0);
        check("hold.evals", eval_total - e0, cand_r.size());
        check("hold.dones", done_total - d0, 1);
        check("hold.proto", proto_err, 0);

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < ROWS; k++) mem[k] = COLS'($urandom);
            set_search(rand_shapes(1'b1));
            rand_scores(30, 15);
            run_search($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
